// File: rtl/multi_timeout_if.sv
// Control/status bundle for multi_timeout: per-channel start/cancel/mode/limit in, busy/done/expired/count out.
// The prescale signal and PRE_LEN exist only when MULTI_TIMEOUT_PRESCALE_EN is defined.
interface multi_timeout_if #(
  parameter int N_CH    = 4,
  parameter int CNT_LEN = 8
`ifdef MULTI_TIMEOUT_PRESCALE_EN
  ,
  parameter int PRE_LEN = 4
`endif
);
  logic [N_CH-1:0]         start;
  logic [N_CH-1:0]         cancel;
  logic [N_CH-1:0]         periodic;
  logic [N_CH*CNT_LEN-1:0] timeout;
`ifdef MULTI_TIMEOUT_PRESCALE_EN
  logic [PRE_LEN-1:0]      prescale;
`endif
  logic [N_CH-1:0]         busy;
  logic [N_CH-1:0]         done;
  logic [N_CH-1:0]         expired;
  logic [N_CH*CNT_LEN-1:0] count;

`ifdef MULTI_TIMEOUT_PRESCALE_EN
  modport master (output start, cancel, periodic, timeout, prescale,
                  input  busy, done, expired, count);
  modport slave  (input  start, cancel, periodic, timeout, prescale,
                  output busy, done, expired, count);
`else
  modport master (output start, cancel, periodic, timeout,
                  input  busy, done, expired, count);
  modport slave  (input  start, cancel, periodic, timeout,
                  output busy, done, expired, count);
`endif
endinterface

// File: rtl/multi_timeout.sv
// N independent countdown channels with one-shot/periodic modes, retrigger and cancel.
// Optional per-channel tick prescaler enabled by defining MULTI_TIMEOUT_PRESCALE_EN.
module multi_timeout #(
  parameter int N_CH    = 4,
  parameter int CNT_LEN = 8
`ifdef MULTI_TIMEOUT_PRESCALE_EN
  ,
  parameter int PRE_LEN = 4
`endif
) (
  input logic           clk,
  input logic           rst,
  multi_timeout_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  assign bus.done = ~bus.busy;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t             state, state_next;
    logic [CNT_LEN-1:0] cnt, cnt_next;
    logic [CNT_LEN-1:0] limit, limit_next;
    logic               mode, mode_next;
    logic               exp_q, exp_next;
    logic               load;
    logic               tick;
    logic [CNT_LEN-1:0] tmo;

    assign tmo = bus.timeout[i*CNT_LEN +: CNT_LEN];

`ifdef MULTI_TIMEOUT_PRESCALE_EN
    logic [PRE_LEN-1:0] pre_cnt, pre_cnt_next;
    logic [PRE_LEN-1:0] pre_lim, pre_lim_next;

    assign tick = (pre_cnt == pre_lim);
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= IDLE;
        cnt     <= '0;
        limit   <= '0;
        mode    <= 1'b0;
        exp_q   <= 1'b0;
`ifdef MULTI_TIMEOUT_PRESCALE_EN
        pre_cnt <= '0;
        pre_lim <= '0;
`endif
      end else begin
        state   <= state_next;
        cnt     <= cnt_next;
        limit   <= limit_next;
        mode    <= mode_next;
        exp_q   <= exp_next;
`ifdef MULTI_TIMEOUT_PRESCALE_EN
        pre_cnt <= pre_cnt_next;
        pre_lim <= pre_lim_next;
`endif
      end
    end

    // Cancel dominates everything; a start on an expiry edge keeps the pulse and restarts.
    always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      limit_next   = limit;
      mode_next    = mode;
      exp_next     = 1'b0;
      load         = 1'b0;
`ifdef MULTI_TIMEOUT_PRESCALE_EN
      pre_cnt_next = pre_cnt;
      pre_lim_next = pre_lim;
`endif
      case (state)
        IDLE: begin
          if (bus.start[i] && !bus.cancel[i]) begin
            state_next = RUN;
            load       = 1'b1;
          end
        end
        RUN: begin
          if (bus.cancel[i]) begin
            state_next   = IDLE;
            cnt_next     = '0;
`ifdef MULTI_TIMEOUT_PRESCALE_EN
            pre_cnt_next = '0;
`endif
          end else begin
            if (tick) begin
              if (cnt >= limit) begin
                exp_next = 1'b1;
                if (mode) cnt_next = CNT_LEN'(1);
                else      state_next = IDLE;
              end else begin
                cnt_next = cnt + 1'b1;
              end
`ifdef MULTI_TIMEOUT_PRESCALE_EN
              pre_cnt_next = '0;
            end else begin
              pre_cnt_next = pre_cnt + 1'b1;
`endif
            end
            if (bus.start[i]) begin
              state_next = RUN;
              load       = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
      if (load) begin
        limit_next   = tmo;
        mode_next    = bus.periodic[i];
        cnt_next     = CNT_LEN'(1);
`ifdef MULTI_TIMEOUT_PRESCALE_EN
        pre_cnt_next = '0;
        pre_lim_next = bus.prescale;
`endif
      end
    end

    assign bus.busy[i]                      = (state == RUN);
    assign bus.expired[i]                   = exp_q;
    assign bus.count[i*CNT_LEN +: CNT_LEN]  = cnt;
  end

endmodule

// File: tb/tb_multi_timeout.sv
// Scoreboard bench for multi_timeout: stimulus pushes expected expiry edges, a forked monitor pops them.
// Level checks (busy/done/count) are hand-computed per directed vector.
module tb_multi_timeout;
  localparam int N_CH    = 4;
  localparam int CNT_LEN = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_edge [N_CH][$];
  int   e;
  int   r;

  multi_timeout_if #(.N_CH(N_CH), .CNT_LEN(CNT_LEN)) bus ();

  multi_timeout #(.N_CH(N_CH), .CNT_LEN(CNT_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic [3:0] cn,
                               input logic [3:0] pe, input logic [31:0] tmo);
    bus.start    = st;
    bus.cancel   = cn;
    bus.periodic = pe;
    bus.timeout  = tmo;
    step(1);
    bus.start    = '0;
    bus.cancel   = '0;
  endtask

  function automatic logic [7:0] cnt_of(input int ch);
    return bus.count[ch*CNT_LEN +: CNT_LEN];
  endfunction

  // Every expected pulse must appear on its edge, and no pulse may appear otherwise.
  task automatic monitor();
    logic want;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          want = 1'b0;
          if (exp_edge[ch].size() > 0 && exp_edge[ch][0] == cyc) begin
            want = 1'b1;
            void'(exp_edge[ch].pop_front());
          end
          if (want || bus.expired[ch])
            checkOutput($sformatf("expired[%0d]", ch), 32'(bus.expired[ch]), 32'(want));
        end
      end
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " busy"},    32'(bus.busy),    32'h0);
    checkOutput({tag, " done"},    32'(bus.done),    32'hF);
    checkOutput({tag, " expired"}, 32'(bus.expired), 32'h0);
    checkOutput({tag, " count"},   bus.count,        32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.start    = '0;
    bus.cancel   = '0;
    bus.periodic = '0;
    bus.timeout  = '0;
`ifdef MULTI_TIMEOUT_PRESCALE_EN
    bus.prescale = '0;
`endif
    rst = 1'b1;
    fork
      monitor();
    join_none
    step(2);
    checkReset("reset");
    rst = 1'b0;
    step(1);

    // ch0 one-shot L=5
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0005);
    e = cyc;
    exp_edge[0].push_back(e + 5);
    checkOutput("s1 busy0 start", 32'(bus.busy[0]), 1);
    checkOutput("s1 count0 start", 32'(cnt_of(0)), 1);
    for (int k = 2; k <= 5; k++) begin
      step(1);
      checkOutput("s1 count0", 32'(cnt_of(0)), 32'(k));
      checkOutput("s1 busy0", 32'(bus.busy[0]), 1);
    end
    step(1);
    checkOutput("s1 busy0 end", 32'(bus.busy[0]), 0);
    checkOutput("s1 done0 end", 32'(bus.done[0]), 1);
    checkOutput("s1 count0 end", 32'(cnt_of(0)), 5);
    step(1);
    checkOutput("s1 count0 hold", 32'(cnt_of(0)), 5);

    // ch1 periodic L=3
    applyStimulus(4'b0010, 4'b0000, 4'b0010, 32'h0000_0300);
    e = cyc;
    exp_edge[1].push_back(e + 3);
    exp_edge[1].push_back(e + 6);
    exp_edge[1].push_back(e + 9);
    for (int j = 1; j <= 10; j++) begin
      step(1);
      checkOutput("s2 count1", 32'(cnt_of(1)), 32'((j % 3) + 1));
      checkOutput("s2 busy1", 32'(bus.busy[1]), 1);
    end
    applyStimulus(4'b0000, 4'b0010, 4'b0000, 32'h0);
    checkOutput("s2 busy1 cancel", 32'(bus.busy[1]), 0);
    checkOutput("s2 count1 cancel", 32'(cnt_of(1)), 0);

    // ch2 L=0, ch3 L=1, ch0 L=200 on the same edge
    applyStimulus(4'b1101, 4'b0000, 4'b0000, 32'h0100_00C8);
    e = cyc;
    exp_edge[2].push_back(e + 1);
    exp_edge[3].push_back(e + 1);
    checkOutput("s3 busy start", 32'(bus.busy), 32'hD);
    step(1);
    checkOutput("s3 busy after", 32'(bus.busy), 32'h1);
    checkOutput("s3 count0", 32'(cnt_of(0)), 2);
    checkOutput("s3 count2", 32'(cnt_of(2)), 1);
    checkOutput("s3 count3", 32'(cnt_of(3)), 1);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, 32'h0);
    checkOutput("s3 busy0 cancel", 32'(bus.busy[0]), 0);

    // ch0 L=6 retriggered at count 4 with L=2, then start on the expiry edge with L=3
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0006);
    step(3);
    checkOutput("s4 count0 pre", 32'(cnt_of(0)), 4);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0002);
    r = cyc;
    exp_edge[0].push_back(r + 2);
    checkOutput("s4 count0 retrig", 32'(cnt_of(0)), 1);
    step(1);
    checkOutput("s4 count0 r+1", 32'(cnt_of(0)), 2);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0003);
    exp_edge[0].push_back(r + 5);
    checkOutput("s4 busy0 restart", 32'(bus.busy[0]), 1);
    checkOutput("s4 count0 restart", 32'(cnt_of(0)), 1);
    step(2);
    checkOutput("s4 count0 r+4", 32'(cnt_of(0)), 3);
    checkOutput("s4 busy0 r+4", 32'(bus.busy[0]), 1);
    step(1);
    checkOutput("s4 busy0 r+5", 32'(bus.busy[0]), 0);
    checkOutput("s4 count0 r+5", 32'(cnt_of(0)), 3);

    // cancel mid-count, cancel+start in IDLE and RUN, cancel on expiry edge
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_000A);
    step(2);
    checkOutput("s5 count0 pre", 32'(cnt_of(0)), 3);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, 32'h0);
    checkOutput("s5 busy0 cancel", 32'(bus.busy[0]), 0);
    checkOutput("s5 count0 cancel", 32'(cnt_of(0)), 0);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 32'h0000_0005);
    checkOutput("s5 busy0 idle c+s", 32'(bus.busy[0]), 0);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_000A);
    step(1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 32'h0000_0005);
    checkOutput("s5 busy0 run c+s", 32'(bus.busy[0]), 0);
    checkOutput("s5 count0 run c+s", 32'(cnt_of(0)), 0);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0002);
    step(1);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, 32'h0);
    checkOutput("s5 busy0 cancel@exp", 32'(bus.busy[0]), 0);
    checkOutput("s5 count0 cancel@exp", 32'(cnt_of(0)), 0);

    // ch3 all-ones limit
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 32'hFF00_0000);
    e = cyc;
    exp_edge[3].push_back(e + 255);
    step(254);
    checkOutput("s6 count3 max", 32'(cnt_of(3)), 255);
    checkOutput("s6 busy3 max", 32'(bus.busy[3]), 1);
    step(1);
    checkOutput("s6 busy3 end", 32'(bus.busy[3]), 0);

    // asynchronous reset mid-count
    applyStimulus(4'b0011, 4'b0000, 4'b0010, 32'h0000_0432);
    step(2);
    #2;
    rst = 1'b1;
    #1;
    checkReset("async rst");
    step(1);
    rst = 1'b0;
    step(1);
    checkReset("post rst");

`ifdef MULTI_TIMEOUT_PRESCALE_EN
    bus.prescale = 4'd2;
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0004);
    step(6);
    checkOutput("p count0 e+6", 32'(cnt_of(0)), 3);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0004);
    r = cyc;
    exp_edge[0].push_back(r + 12);
    step(5);
    checkOutput("p busy0 r+5", 32'(bus.busy[0]), 1);
    checkOutput("p count0 r+5", 32'(cnt_of(0)), 2);
    step(6);
    checkOutput("p busy0 r+11", 32'(bus.busy[0]), 1);
    checkOutput("p count0 r+11", 32'(cnt_of(0)), 4);
    step(1);
    checkOutput("p busy0 r+12", 32'(bus.busy[0]), 0);
    bus.prescale = '0;
`endif

    step(3);
    for (int ch = 0; ch < N_CH; ch++)
      checkOutput($sformatf("pending expiries ch%0d", ch), 32'(exp_edge[ch].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
